// File: rtl/haze_pkg.sv
// Shared constants and types for the haze-removal AXI-Stream framer.
// Pixels arrive as {8'h00,R,G,B}; the top byte is always cleared on the way through.
package haze_pkg;

  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;
  localparam int PIXEL_W        = 32;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  function automatic logic [PIXEL_W-1:0] strip_alpha(input logic [PIXEL_W-1:0] px);
    return px & 32'h00FF_FFFF;
  endfunction

endpackage

// File: rtl/haze_axis_skid.sv
// Two-entry skid buffer between the upstream haze pipeline and the framed output.
// head_q is always the beat being presented; tail_q only holds data while FULL.
module haze_axis_skid
  import haze_pkg::*;
(
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enable,
  input  logic [PIXEL_W-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [PIXEL_W-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready
);

  skid_state_t        state, state_next;
  logic [PIXEL_W-1:0] head_q, tail_q;
  logic               ready_q;
  logic               push, pop;
  logic               load_head_in, load_tail_in, load_head_tail;

  assign push = s_valid && ready_q;
  assign pop  = (state != EMPTY) && m_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_tail_in   = 1'b0;
    load_head_tail = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_next   = FULL;
          load_tail_in = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Ready looks at the next state so it is already low in the first FULL cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      if (load_head_in)        head_q <= strip_alpha(s_data);
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail_in)        tail_q <= strip_alpha(s_data);
      ready_q <= enable && (state_next != FULL);
    end
  end

  assign s_ready = ready_q;
  assign m_valid = (state != EMPTY);
  assign m_data  = head_q;

endmodule

// File: rtl/haze_axis_framer.sv
// Frames the haze-removal pixel stream: tracks column/row of the presented beat,
// raises TLAST at end of line, TUSER at start of frame, and counts completed frames.
module haze_axis_framer
  import haze_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enable,
  input  logic [PIXEL_W-1:0] S_AXIS_TDATA,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  output logic [PIXEL_W-1:0] M_AXIS_TDATA,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TUSER,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic             out_valid;
  logic             out_fire;
  logic             frame_end;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [15:0]      frame_count_q;
  logic             frame_done_q;

  haze_axis_skid u_skid (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .enable  (enable),
    .s_data  (S_AXIS_TDATA),
    .s_valid (S_AXIS_TVALID),
    .s_ready (S_AXIS_TREADY),
    .m_data  (M_AXIS_TDATA),
    .m_valid (out_valid),
    .m_ready (M_AXIS_TREADY)
  );

  assign out_fire  = out_valid && M_AXIS_TREADY;
  assign frame_end = out_fire && (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Position tracks the beat on the output port, so it only moves on output handshakes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (frame_end) frame_count_q <= frame_count_q + 16'd1;
      if (out_fire) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Side-band flags are qualified by valid so nothing leaks out while idle or in reset.
  assign M_AXIS_TVALID = out_valid;
  assign M_AXIS_TLAST  = out_valid && (col_q == COL_LAST);
  assign M_AXIS_TUSER  = out_valid && (col_q == '0) && (row_q == '0);
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_haze_axis_framer.sv
// Directed bench for haze_axis_framer on a 4x2 image: streaming, back-pressure,
// enable gating, mid-frame reset and frame counter wrap.
module tb_haze_axis_framer;

  localparam int W = 4;
  localparam int H = 2;

  logic        ACLK;
  logic        ARESET;
  logic        enable;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TUSER;
  logic        frame_done;
  logic [15:0] frame_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [33:0] outQ[$];
  int          doneCount  = 0;

  haze_axis_framer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Inputs settle 1ns after each rising edge, so the falling edge sees what the next edge will take.
  always @(negedge ACLK) begin
    if (M_AXIS_TVALID && M_AXIS_TREADY)
      outQ.push_back({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA});
    if (frame_done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offers count beats starting at base with junk in the top byte; optionally toggles downstream ready.
  task automatic applyStimulus(input string tag, input logic [31:0] base, input int count,
                               input bit toggleReady);
    int  sent   = 0;
    int  cycles = 0;
    bit  fire;
    while (sent < count && cycles < 300) begin
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = 32'hA500_0000 | (base + 32'(sent));
      @(negedge ACLK);
      fire = S_AXIS_TREADY;
      @(posedge ACLK);
      #1;
      if (fire) sent++;
      if (toggleReady) M_AXIS_TREADY = ~M_AXIS_TREADY;
      cycles++;
    end
    S_AXIS_TVALID = 1'b0;
    checkOutput({tag, "_sent"}, 32'(sent), 32'(count));
  endtask

  task automatic applyReset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("rst_tdata",  M_AXIS_TDATA,       32'd0);
    checkOutput("rst_tlast",  32'(M_AXIS_TLAST),  32'd0);
    checkOutput("rst_tuser",  32'(M_AXIS_TUSER),  32'd0);
    checkOutput("rst_sready", 32'(S_AXIS_TREADY), 32'd0);
    checkOutput("rst_done",   32'(frame_done),    32'd0);
    checkOutput("rst_fcount", 32'(frame_count),   32'd0);
    ARESET = 1'b0;
  endtask

  task automatic drainOutput();
    M_AXIS_TREADY = 1'b1;
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  // Every scenario starts at pixel (0,0), so index i is also the frame position.
  task automatic checkQueue(input string tag, input int base, input logic [31:0] first, input int count);
    logic [33:0] entry;
    checkOutput({tag, "_count"}, 32'(outQ.size() - base), 32'(count));
    for (int i = 0; i < count; i++) begin
      if (base + i < outQ.size()) begin
        entry = outQ[base + i];
        checkOutput($sformatf("%s_data%0d", tag, i), entry[31:0], first + 32'(i));
        checkOutput($sformatf("%s_last%0d", tag, i), 32'(entry[32]), 32'((i % W) == W - 1));
        checkOutput($sformatf("%s_user%0d", tag, i), 32'(entry[33]), 32'((i % (W * H)) == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int qBase;
    int doneBase;
    ARESET        = 1'b1;
    enable        = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;

    $display("[TB] streaming one frame with ready held high");
    applyReset();
    qBase = outQ.size(); doneBase = doneCount;
    applyStimulus("s1a", 32'h1, 1, 1'b0);
    checkOutput("s1_lat_valid", 32'(M_AXIS_TVALID), 32'd1);
    checkOutput("s1_lat_data",  M_AXIS_TDATA,       32'h1);
    checkOutput("s1_lat_user",  32'(M_AXIS_TUSER),  32'd1);
    applyStimulus("s1b", 32'h2, 7, 1'b0);
    drainOutput();
    checkQueue("s1", qBase, 32'h1, 8);
    checkOutput("s1_done",   32'(doneCount - doneBase), 32'd1);
    checkOutput("s1_fcount", 32'(frame_count),          32'd1);

    $display("[TB] back-pressure: buffer fills and holds");
    M_AXIS_TREADY = 1'b0;
    qBase = outQ.size();
    applyStimulus("s2a", 32'h11, 2, 1'b0);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'hA500_0013;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK);
      checkOutput("s2_sready", 32'(S_AXIS_TREADY), 32'd0);
      checkOutput("s2_hold_v", 32'(M_AXIS_TVALID), 32'd1);
      checkOutput("s2_hold_d", M_AXIS_TDATA,       32'h11);
      checkOutput("s2_hold_u", 32'(M_AXIS_TUSER),  32'd1);
      checkOutput("s2_hold_l", 32'(M_AXIS_TLAST),  32'd0);
      @(posedge ACLK);
      #1;
    end
    checkOutput("s2_no_out", 32'(outQ.size() - qBase), 32'd0);
    M_AXIS_TREADY = 1'b1;
    applyStimulus("s2b", 32'h13, 6, 1'b0);
    drainOutput();
    checkQueue("s2", qBase, 32'h11, 8);
    checkOutput("s2_fcount", 32'(frame_count), 32'd2);

    $display("[TB] downstream ready toggling over three frames");
    applyReset();
    qBase = outQ.size(); doneBase = doneCount;
    applyStimulus("s3", 32'h21, 24, 1'b1);
    drainOutput();
    checkQueue("s3", qBase, 32'h21, 24);
    checkOutput("s3_done",   32'(doneCount - doneBase), 32'd3);
    checkOutput("s3_fcount", 32'(frame_count),          32'd3);

    $display("[TB] enable dropped with a beat still buffered");
    applyReset();
    qBase = outQ.size();
    applyStimulus("s4a", 32'h31, 3, 1'b0);
    enable = 1'b0;
    @(posedge ACLK);
    #1;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'hA500_0034;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      checkOutput("s4_sready", 32'(S_AXIS_TREADY), 32'd0);
      @(posedge ACLK);
      #1;
    end
    checkOutput("s4_drained", 32'(outQ.size() - qBase), 32'd3);
    if (outQ.size() - qBase >= 3)
      checkOutput("s4_third", outQ[qBase + 2][31:0], 32'h33);
    enable = 1'b1;
    applyStimulus("s4b", 32'h34, 5, 1'b0);
    drainOutput();
    checkQueue("s4", qBase, 32'h31, 8);
    checkOutput("s4_fcount", 32'(frame_count), 32'd1);

    $display("[TB] reset in the middle of a frame");
    applyStimulus("s5a", 32'h41, 5, 1'b0);
    applyReset();
    qBase = outQ.size();
    applyStimulus("s5b", 32'h51, 8, 1'b0);
    drainOutput();
    checkQueue("s5", qBase, 32'h51, 8);
    checkOutput("s5_fcount", 32'(frame_count), 32'd1);

    $display("[TB] frame counter wrap");
    force dut.frame_count_q = 16'hFFFF;
    @(posedge ACLK);
    #1;
    release dut.frame_count_q;
    checkOutput("s6_preload", 32'(frame_count), 32'h0000_FFFF);
    doneBase = doneCount;
    applyStimulus("s6", 32'h61, 8, 1'b0);
    drainOutput();
    checkOutput("s6_fcount", 32'(frame_count),          32'd0);
    checkOutput("s6_done",   32'(doneCount - doneBase), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
